range_stream_tx: RTL and testbench

- Transmit side of the range-finder streaming interface.
- A host loads up to DEPTH samples into an internal buffer, then pulses start.
- The block streams the samples out as one contiguous go-high burst, waits for the range finder's finish, and captures the returned range.
- Reports timeout or empty-start errors. Used as the on-chip driver and self-checker for the range finder.

---
 rtl/range_stream_tx_if.sv | 28 ++
 rtl/range_stream_tx.sv | 139 +++++++++++++
 tb/tb_range_stream_tx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_stream_tx_if.sv
// Host/range-finder signal bundle for range_stream_tx.
// The slave modport is the transmitter; the master modport is the host plus range finder.
interface range_stream_tx_if #(
  parameter int unsigned WIDTH = 10
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             start;
  logic             busy;
  logic             go;
  logic [WIDTH-1:0] data_out;
  logic             finish;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             error;

  modport master (
    output load_valid, load_data, start, finish, range_in,
    input  load_ready, busy, go, data_out, result, result_valid, error
  );

  modport slave (
    input  load_valid, load_data, start, finish, range_in,
    output load_ready, busy, go, data_out, result, result_valid, error
  );
endinterface

// File: rtl/range_stream_tx.sv
// Range-finder transmit driver: buffers host samples, streams them as one
// contiguous go burst, then captures the returned range or flags a timeout.
module range_stream_tx #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  range_stream_tx_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             error_q, error_d;
  logic             load_fire;
  logic [AW-1:0]    first_ptr;

  assign bus.load_ready   = (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && !bus.start;
  assign bus.busy         = (state_q == S_STREAM) || (state_q == S_WAIT);
  assign bus.go           = go_q;
  assign bus.data_out     = data_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;

  assign load_fire = bus.load_valid && bus.load_ready;
  // Oldest sample; a full buffer wraps so this equals wr_ptr.
  assign first_ptr = wr_ptr_q - count_q[AW-1:0];

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    timer_d        = timer_q;
    go_d           = go_q;
    data_d         = data_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;

    if (load_fire) begin
      mem_d[wr_ptr_q] = bus.load_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      count_d         = count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (count_q != '0) begin
            // First sample is issued on the start edge so go rises the next cycle.
            state_d        = S_STREAM;
            result_valid_d = 1'b0;
            error_d        = 1'b0;
            go_d           = 1'b1;
            data_d         = mem_q[first_ptr];
            rd_ptr_d       = first_ptr + 1'b1;
            count_d        = count_q - 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (count_q == '0) begin
          state_d = S_WAIT;
          go_d    = 1'b0;
          data_d  = '0;
          timer_d = '0;
        end else begin
          data_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.finish) begin
          state_d        = S_IDLE;
          result_d       = bus.range_in;
          result_valid_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      timer_q        <= '0;
      go_q           <= 1'b0;
      data_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      timer_q        <= timer_d;
      go_q           <= go_d;
      data_q         <= data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_range_stream_tx.sv
// Scoreboard bench for range_stream_tx with a behavioural range-finder model
// (returns max-min of each burst) and a decoupled output monitor.
module tb_range_stream_tx;
  localparam int unsigned W = 10;
  localparam int unsigned D = 8;
  localparam int unsigned T = 16;

  typedef struct {
    bit          timeout;
    int unsigned value;
    int unsigned wait_cyc;
  } outcome_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  range_stream_tx_if #(.WIDTH(W)) bus();

  range_stream_tx #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_samples[$];
  int unsigned exp_len[$];
  int unsigned loaded[$];
  outcome_t    exp_out[$];
  int unsigned exp_last = 0;
  bit          exp_rv = 1'b0;
  bit          abort = 1'b0;
  bit          rf_enable = 1'b1;
  int unsigned rf_delay = 2;
  int unsigned rf_spur_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents output activity.
  initial begin
    bit prev_go, prev_busy;
    int unsigned run_len, wait_cnt;
    outcome_t o;
    prev_go = 0; prev_busy = 0; run_len = 0; wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.go) begin
          if (exp_samples.size() == 0) note_fail("unexpected_go");
          else chk("go_data", bus.data_out, exp_samples.pop_front());
          run_len++;
        end else begin
          chk("idle_data", bus.data_out, 0);
        end
        if (prev_go && !bus.go) begin
          if (!abort) begin
            if (exp_len.size() == 0) note_fail("unexpected_burst_end");
            else chk("burst_len", run_len, exp_len.pop_front());
          end
          run_len = 0;
          wait_cnt = 0;
        end
        if (bus.busy && !bus.go) wait_cnt++;
        if (prev_busy && !bus.busy) begin
          if (abort) begin
            abort = 1'b0;
          end else if (exp_out.size() == 0) begin
            note_fail("unexpected_done");
          end else begin
            o = exp_out.pop_front();
            chk("done_error", bus.error, o.timeout);
            chk("done_result_valid", bus.result_valid, !o.timeout);
            chk("done_result", bus.result, o.value);
            chk("done_wait_cycles", wait_cnt, o.wait_cyc);
          end
        end
      end
      prev_go   = bus.go;
      prev_busy = bus.busy;
    end
  end

  // Range-finder model: collects each burst, answers with max-min after rf_delay.
  initial begin
    int unsigned smp[$];
    int unsigned mx, mn, spur_ack;
    bit prev_go;
    prev_go = 0; spur_ack = 0;
    bus.finish = 1'b0;
    bus.range_in = '0;
    forever begin
      @(negedge clock);
      if (bus.go) begin
        smp.push_back(int'(bus.data_out));
      end else if (prev_go) begin
        mx = 0; mn = 32'hFFFF_FFFF;
        foreach (smp[i]) begin
          if (smp[i] > mx) mx = smp[i];
          if (smp[i] < mn) mn = smp[i];
        end
        smp.delete();
        if (rf_enable) begin
          repeat (rf_delay - 1) @(negedge clock);
          bus.finish = 1'b1;
          bus.range_in = W'(mx - mn);
          @(negedge clock);
          bus.finish = 1'b0;
          bus.range_in = W'($urandom);
        end
      end else if (rf_spur_req != spur_ack) begin
        spur_ack = rf_spur_req;
        bus.finish = 1'b1;
        bus.range_in = W'($urandom);
        @(negedge clock);
        bus.finish = 1'b0;
      end
      prev_go = bus.go;
    end
  end

  task automatic do_reset();
    bit was_busy;
    was_busy = (bus.busy === 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    exp_samples.delete(); exp_len.delete(); exp_out.delete(); loaded.delete();
    exp_last = 0; exp_rv = 1'b0;
    if (was_busy) abort = 1'b1;
    bus.load_valid = 1'b0; bus.start = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_go", bus.go, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_load_ready", bus.load_ready, 1);
  endtask

  // Offers one sample; leaves load_valid high so successive calls are back to back.
  task automatic load(input int unsigned v);
    bit rdy;
    bus.load_valid = 1'b1;
    bus.load_data = W'(v);
    bus.start = 1'b0;
    #1;
    rdy = (loaded.size() < D);
    chk("load_ready", bus.load_ready, rdy);
    @(posedge clock); #1;
    if (rdy) loaded.push_back(v);
  endtask

  task automatic do_start(input bit fin_en, input int unsigned dly);
    int unsigned mx, mn;
    outcome_t o;
    rf_enable = fin_en;
    rf_delay = dly;
    bus.start = 1'b1;
    #1;
    chk("ready_during_start", bus.load_ready, 0);
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.load_valid = 1'b0;
    if (loaded.size() == 0) begin
      chk("empty_error", bus.error, 1);
      chk("empty_busy", bus.busy, 0);
      chk("empty_go", bus.go, 0);
      chk("empty_result_valid", bus.result_valid, exp_rv);
    end else begin
      mx = 0; mn = 32'hFFFF_FFFF;
      foreach (loaded[i]) begin
        exp_samples.push_back(loaded[i]);
        if (loaded[i] > mx) mx = loaded[i];
        if (loaded[i] < mn) mn = loaded[i];
      end
      exp_len.push_back(loaded.size());
      o.timeout = !fin_en;
      o.value = fin_en ? (mx - mn) : exp_last;
      o.wait_cyc = fin_en ? dly : T;
      exp_out.push_back(o);
      exp_last = o.value;
      exp_rv = fin_en;
      loaded.delete();
      chk("start_go", bus.go, 1);
      chk("start_busy", bus.busy, 1);
      chk("start_error_clr", bus.error, 0);
      chk("start_rv_clr", bus.result_valid, 0);
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (bus.busy) note_fail("busy_timeout");
    @(posedge clock); #1;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    do_reset();
    check_reset_vals();

    // Basic burst: 5, 100, 20 -> range 95.
    load(5); load(100); load(20);
    bus.load_valid = 1'b0;
    do_start(1, 2);
    wait_idle();
    chk("t1_result", bus.result, 95);
    chk("t1_result_valid", bus.result_valid, 1);
    chk("t1_error", bus.error, 0);
    chk("t1_busy", bus.busy, 0);

    // Stray finish while idle is ignored.
    rf_spur_req++;
    repeat (3) @(posedge clock); #1;
    chk("spur_result", bus.result, 95);
    chk("spur_result_valid", bus.result_valid, 1);

    // Ten offers into an 8-deep buffer; last two dropped.
    for (int i = 0; i < 10; i++) load(11 * i + 3);
    bus.load_valid = 1'b0;
    do_start(1, 3);
    wait_idle();

    // Empty start, then a one-sample burst clears the error.
    do_start(1, 2);
    chk("empty_stays_idle", bus.busy, 0);
    load(7);
    bus.load_valid = 1'b0;
    do_start(1, 1);
    wait_idle();
    chk("after_empty_error", bus.error, 0);

    // Timeout: finish never comes; result keeps the old value (0 from 7-7).
    load(40); load(300); load(12);
    bus.load_valid = 1'b0;
    do_start(0, 1);
    wait_idle();
    chk("to_error", bus.error, 1);
    chk("to_result_valid", bus.result_valid, 0);

    // Reset on the second go cycle of a 5-sample burst.
    for (int i = 0; i < 5; i++) load(50 + 20 * i);
    bus.load_valid = 1'b0;
    do_start(1, 3);
    @(posedge clock); #1;
    chk("rst_mid_go", bus.go, 1);
    do_reset();
    check_reset_vals();
    repeat (8) @(posedge clock); #1;
    chk("post_rst_result_valid", bus.result_valid, 0);
    chk("post_rst_result", bus.result, 0);

    // Load and start together: the load is refused.
    load(200); load(900);
    bus.load_data = W'(555);
    do_start(1, 2);
    wait_idle();

    // Single 0x3FF sample, finish returns 0; finish on the last timer cycle also wins.
    load(10'h3FF);
    bus.load_valid = 1'b0;
    do_start(1, 1);
    wait_idle();
    chk("single_result", bus.result, 0);
    chk("single_result_valid", bus.result_valid, 1);
    load(1); load(2);
    bus.load_valid = 1'b0;
    do_start(1, T);
    wait_idle();

    // Randomized bursts.
    for (int r = 0; r < 12; r++) begin
      int unsigned n;
      bit fin;
      n = $urandom_range(1, D);
      fin = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < int'(n); i++) load($urandom_range(0, 1023));
      bus.load_valid = 1'b0;
      do_start(fin, $urandom_range(1, T));
      wait_idle();
    end

    repeat (4) @(posedge clock); #1;
    if (exp_samples.size() != 0 || exp_len.size() != 0 || exp_out.size() != 0)
      note_fail("scoreboard_not_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
